// File: rtl/jkdrv_pkg.sv
// Shared types and the per-bit J/K excitation for the JK drive sequencer.
// JKDRV_TOGGLE_PREF_EN selects toggle-preferring don't-care resolution; default is pure set/reset.
package jkdrv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_e;

  // Returns {j, k} that moves one flip-flop from cur to tgt; unchanged bits never get j=k=1
  function automatic logic [1:0] jk_excite(input logic cur, input logic tgt);
`ifdef JKDRV_TOGGLE_PREF_EN
    return (cur != tgt) ? 2'b11 : 2'b00;
`else
    return {~cur & tgt, cur & ~tgt};
`endif
  endfunction

endpackage

// File: rtl/jkdrv_fifo.sv
// Synchronous target-word FIFO with count-based full/empty; read data is the current head.
module jkdrv_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty_c,
  output logic [CW-1:0]    o_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full_c;
  logic             w_push;
  logic             w_pop;

  assign w_full_c  = (r_count == CW'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign w_push    = i_push && !w_full_c;
  assign w_pop     = i_pop && !o_empty_c;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/jk_drive_sequencer.sv
// Buffers target words and drives a JK flip-flop bank toward them, checking read-back after each drive.
// Build macro: JKDRV_TOGGLE_PREF_EN (toggle-preferring excitation, see jkdrv_pkg).
module jk_drive_sequencer
  import jkdrv_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             drv_valid,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] shadow_q,
  output logic             err,
  output logic [WIDTH-1:0] err_bits,
  input  logic             err_clr
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  state_e           r_state;
  state_e           w_next_state;
  logic             w_push;
  logic             w_pop;
  logic             w_empty_c;
  logic [CW-1:0]    w_count;
  logic [WIDTH-1:0] w_head;
  logic [WIDTH-1:0] w_j_nxt;
  logic [WIDTH-1:0] w_k_nxt;
  logic [WIDTH-1:0] w_mismatch;
  logic [WIDTH-1:0] r_j;
  logic [WIDTH-1:0] r_k;
  logic             r_drv_valid;
  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_target;
  logic             r_err;
  logic [WIDTH-1:0] r_err_bits;

  assign in_ready = (w_count != CW'(DEPTH));
  assign w_push   = in_valid && in_ready;

  jkdrv_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_push),
    .i_wr_data (in_data),
    .i_pop     (w_pop),
    .o_rd_data (w_head),
    .o_empty_c (w_empty_c),
    .o_count   (w_count)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (!w_empty_c) w_next_state = DRIVE;
      DRIVE:   w_next_state = CHECK;
      CHECK:   w_next_state = w_empty_c ? IDLE : DRIVE;
      default: w_next_state = IDLE;
    endcase
  end

  // Next-cycle drive values; a pop always launches a DRIVE cycle from the current shadow
  always_comb begin
    w_pop      = 1'b0;
    w_j_nxt    = '0;
    w_k_nxt    = '0;
    w_mismatch = '0;
    if (r_state != DRIVE && !w_empty_c) begin
      w_pop = 1'b1;
      for (int i = 0; i < int'(WIDTH); i++) begin
        {w_j_nxt[i], w_k_nxt[i]} = jk_excite(r_shadow[i], w_head[i]);
      end
    end
    if (r_state == CHECK) w_mismatch = q_fb ^ r_shadow;
  end

  // A fresh mismatch takes priority over a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_j         <= '0;
      r_k         <= '0;
      r_drv_valid <= 1'b0;
      r_shadow    <= '0;
      r_target    <= '0;
      r_err       <= 1'b0;
      r_err_bits  <= '0;
    end else begin
      r_j         <= w_j_nxt;
      r_k         <= w_k_nxt;
      r_drv_valid <= w_pop;
      if (w_pop) r_target <= w_head;
      if (r_state == DRIVE) r_shadow <= r_target;
      if (w_mismatch != '0) begin
        r_err      <= 1'b1;
        r_err_bits <= err_clr ? w_mismatch : (r_err_bits | w_mismatch);
      end else if (err_clr) begin
        r_err      <= 1'b0;
        r_err_bits <= '0;
      end
    end
  end

  assign j         = r_j;
  assign k         = r_k;
  assign drv_valid = r_drv_valid;
  assign shadow_q  = r_shadow;
  assign err       = r_err;
  assign err_bits  = r_err_bits;

endmodule

// File: tb/tb_jk_drive_sequencer.sv
// Directed self-checking bench for jk_drive_sequencer with a behavioural JK bank on q_fb.
module tb_jk_drive_sequencer;

`ifdef JKDRV_TOGGLE_PREF_EN
  localparam bit TOG = 1'b1;
`else
  localparam bit TOG = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [3:0] j;
  logic [3:0] k;
  logic       drv_valid;
  logic [3:0] q_fb;
  logic [3:0] shadow_q;
  logic       err;
  logic [3:0] err_bits;
  logic       err_clr;

  logic [3:0] bank;
  logic [3:0] stuck0;
  int         n_tests;
  int         n_fail;
  int         cyc;
  bit         rec_en;
  logic [3:0] log_j [$];
  logic [3:0] log_k [$];
  int         log_cyc [$];

  jk_drive_sequencer #(.WIDTH(4), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .j         (j),
    .k         (k),
    .drv_valid (drv_valid),
    .q_fb      (q_fb),
    .shadow_q  (shadow_q),
    .err       (err),
    .err_bits  (err_bits),
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // External JK bank; stuck0 forces selected outputs low
  always @(posedge clk) begin
    if (reset) bank <= 4'b0000;
    else       bank <= ((j & ~bank) | (~k & bank)) & ~stuck0;
  end
  assign q_fb = bank;

  always @(negedge clk) begin
    if (rec_en && drv_valid) begin
      log_j.push_back(j);
      log_k.push_back(k);
      log_cyc.push_back(cyc);
    end
  end

  task automatic drive_one(input logic [3:0] w, input logic [3:0] ej, input logic [3:0] ek,
                           input bit clr_on_check, input string name);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (drv_valid !== 1'b1) begin n_fail++; $display("FAIL %s drv_valid: got %b want 1", name, drv_valid); end
    n_tests++;
    if (j !== ej) begin n_fail++; $display("FAIL %s j: got %b want %b", name, j, ej); end
    n_tests++;
    if (k !== ek) begin n_fail++; $display("FAIL %s k: got %b want %b", name, k, ek); end
    @(negedge clk);
    n_tests++;
    if (drv_valid !== 1'b0) begin n_fail++; $display("FAIL %s drv_valid_one_cycle: got %b want 0", name, drv_valid); end
    n_tests++;
    if (shadow_q !== w) begin n_fail++; $display("FAIL %s shadow_q: got %b want %b", name, shadow_q, w); end
    err_clr = clr_on_check;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (j !== 4'b0000 || k !== 4'b0000) begin n_fail++; $display("FAIL reset_jk: got j=%b k=%b want 0000", j, k); end
    n_tests++;
    if (drv_valid !== 1'b0) begin n_fail++; $display("FAIL reset_drv_valid: got %b want 0", drv_valid); end
    n_tests++;
    if (shadow_q !== 4'b0000) begin n_fail++; $display("FAIL reset_shadow: got %b want 0000", shadow_q); end
    n_tests++;
    if (err !== 1'b0 || err_bits !== 4'b0000) begin n_fail++; $display("FAIL reset_err: got %b/%b want 0/0000", err, err_bits); end
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    reset = 1'b0;
  endtask

  task automatic test_excitation();
    drive_one(4'b1010, 4'b1010, TOG ? 4'b1010 : 4'b0000, 1'b0, "exc_1010");
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL exc_1010_err: got %b want 0", err); end
    drive_one(4'b0110, TOG ? 4'b1100 : 4'b0100, TOG ? 4'b1100 : 4'b1000, 1'b0, "exc_0110");
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL exc_0110_err: got %b want 0", err); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] words [7];
    logic [3:0] prev;
    logic [3:0] nxt;
    int  idx;
    int  mcnt;
    bit  pushed;
    bit  saw_full;
    words = '{4'h3, 4'hC, 4'h5, 4'hA, 4'hF, 4'h0, 4'h9};
    prev = 4'b0110;
    idx = 0; mcnt = 0; pushed = 1'b0; saw_full = 1'b0;
    log_j.delete(); log_k.delete(); log_cyc.delete();
    rec_en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      mcnt = mcnt + int'(pushed) - int'(drv_valid);
      n_tests++;
      if (in_ready !== (mcnt != 4)) begin
        n_fail++; $display("FAIL b2b_in_ready@%0d: got %b want %b (count %0d)", c, in_ready, (mcnt != 4), mcnt);
      end
      if (in_ready === 1'b0) saw_full = 1'b1;
      if (idx < 7) begin
        in_valid = 1'b1;
        in_data  = words[idx];
        pushed   = (in_ready === 1'b1);
        if (pushed) idx++;
      end else begin
        in_valid = 1'b0;
        pushed   = 1'b0;
      end
    end
    rec_en = 1'b0;
    n_tests++;
    if (saw_full !== 1'b1) begin n_fail++; $display("FAIL b2b_full_seen: got %b want 1", saw_full); end
    n_tests++;
    if (log_j.size() !== 7) begin n_fail++; $display("FAIL b2b_drive_count: got %0d want 7", log_j.size()); end
    for (int i = 0; i < 7 && i < log_j.size(); i++) begin
      nxt = (log_j[i] & ~prev) | (~log_k[i] & prev);
      n_tests++;
      if (nxt !== words[i]) begin n_fail++; $display("FAIL b2b_word%0d: got %b want %b", i, nxt, words[i]); end
      n_tests++;
      if ((log_j[i] & log_k[i] & ~(prev ^ words[i])) !== 4'b0000) begin
        n_fail++; $display("FAIL b2b_hold_toggle%0d: got j=%b k=%b", i, log_j[i], log_k[i]);
      end
      if (i > 0) begin
        n_tests++;
        if (log_cyc[i] - log_cyc[i-1] !== 2) begin
          n_fail++; $display("FAIL b2b_spacing%0d: got %0d want 2", i, log_cyc[i] - log_cyc[i-1]);
        end
      end
      prev = words[i];
    end
    n_tests++;
    if (err !== 1'b0 || shadow_q !== 4'h9) begin n_fail++; $display("FAIL b2b_final: got err=%b shadow=%b want 0/1001", err, shadow_q); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] a [6];
    int drives;
    a = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = a[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_tests++;
    if (drv_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_in_drive: got %b want 1", drv_valid); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_tests++;
    if (j !== 4'b0000 || k !== 4'b0000 || drv_valid !== 1'b0) begin
      n_fail++; $display("FAIL rmid_outputs: got j=%b k=%b v=%b want 0000/0000/0", j, k, drv_valid);
    end
    n_tests++;
    if (shadow_q !== 4'b0000) begin n_fail++; $display("FAIL rmid_shadow: got %b want 0000", shadow_q); end
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready: got %b want 1", in_ready); end
    drives = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (drv_valid === 1'b1) drives++;
    end
    n_tests++;
    if (drives !== 0) begin n_fail++; $display("FAIL rmid_no_drive: got %0d drives want 0", drives); end
  endtask

  task automatic test_zero();
    drive_one(4'b0000, 4'b0000, 4'b0000, 1'b0, "zero");
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL zero_err: got %b want 0", err); end
  endtask

  task automatic test_err();
    stuck0 = 4'b0100;
    drive_one(4'b0100, 4'b0100, TOG ? 4'b0100 : 4'b0000, 1'b0, "err_stuck2");
    n_tests++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b want 1", err); end
    n_tests++;
    if (err_bits !== 4'b0100) begin n_fail++; $display("FAIL err_bits_set: got %b want 0100", err_bits); end
    stuck0 = 4'b0101;
    drive_one(4'b0001, TOG ? 4'b0101 : 4'b0001, TOG ? 4'b0101 : 4'b0100, 1'b1, "err_clr_race");
    n_tests++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL err_clr_race_err: got %b want 1", err); end
    n_tests++;
    if (err_bits !== 4'b0001) begin n_fail++; $display("FAIL err_clr_race_bits: got %b want 0001", err_bits); end
    stuck0 = 4'b0000;
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_tests++;
    if (err !== 1'b0 || err_bits !== 4'b0000) begin n_fail++; $display("FAIL err_clear: got %b/%b want 0/0000", err, err_bits); end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    cyc      = 0;
    rec_en   = 1'b0;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 4'b0000;
    err_clr  = 1'b0;
    stuck0   = 4'b0000;
    test_reset();
    test_excitation();
    test_back_to_back();
    test_reset_mid();
    test_zero();
    test_err();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
